// File: rtl/sram_req_bridge_if.sv
// Core-side request/response channel for the SRAM request bridge.
interface sram_req_bridge_if #(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [LEN_ADDR-1:0]   req_addr;
    logic [LEN_DATA-1:0]   req_wdata;
    logic [LEN_DATA/8-1:0] req_wstrb;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [LEN_DATA-1:0]   resp_rdata;
    logic                  resp_err;

    // Core side: issues requests and consumes responses.
    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Bridge side: accepts requests and produces responses.
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_req_bridge.sv
// Bridge from a valid/ready request/response channel onto a single-port
// synchronous SRAM with one cycle of read latency. Decodes the address
// window, tracks the single in-flight access and queues responses so that
// core back-pressure never drops SRAM read data.
module sram_req_bridge #(
    parameter int                  LEN_ADDR   = 32,
    parameter int                  LEN_DATA   = 32,
    parameter int                  DEPTH      = 32,
    parameter logic [LEN_ADDR-1:0] BASE_ADDR  = '0,
    parameter int                  RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_req_bridge_if.slave      bus,
    output logic [LEN_ADDR-1:0]   sram_addr,
    output logic [LEN_DATA-1:0]   sram_dina,
    output logic                  sram_ena,
    output logic [LEN_DATA/8-1:0] sram_wea,
    input  logic [LEN_DATA-1:0]   sram_douta
);
    localparam int STRB_W = LEN_DATA / 8;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    // Window size in bytes, one bit wider than the address so that a window
    // covering the whole address space still compares correctly.
    localparam logic [LEN_ADDR:0]  WINDOW   = (LEN_ADDR + 1)'(DEPTH * STRB_W);
    localparam logic [CNT_W:0]     LIMIT    = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [CNT_W-1:0]   FULL     = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    // Address decode and acceptance
    logic [LEN_ADDR-1:0] offset;
    logic                in_range;
    logic                accept;
    logic [CNT_W:0]      outstanding;

    // In-flight access: result appears on sram_douta one cycle after accept
    logic                inflight_q;
    logic                inflight_err_q;

    // Response queue
    logic [LEN_DATA-1:0] fifo_data_q [RESP_DEPTH];
    logic                fifo_err_q  [RESP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                fifo_empty;

    // Result of the in-flight access as seen this cycle
    logic [LEN_DATA-1:0] bypass_data;
    logic                bypass_err;

    logic                push;
    logic                pop;
    logic                bypass_taken;

    // Window decode and request acceptance; ready depends only on registered
    // state so nothing from the response side or req_valid reaches it.
    always_comb begin
        offset        = bus.req_addr - BASE_ADDR;
        in_range      = ({1'b0, offset} < WINDOW);
        outstanding   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        bus.req_ready = (outstanding < LIMIT);
        accept        = bus.req_valid & bus.req_ready & rst_n;
    end

    // SRAM port drive: enable and write strobes only for accepted in-window
    // requests; address is the byte offset into the window.
    always_comb begin
        sram_addr = offset;
        sram_dina = bus.req_wdata;
        sram_ena  = accept & in_range;
        sram_wea  = sram_ena ? bus.req_wstrb : '0;
    end

    // Response selection: queued responses are older than the in-flight one,
    // so the queue head wins; otherwise the in-flight result goes straight out.
    always_comb begin
        fifo_empty  = (count_q == '0);
        bypass_err  = inflight_err_q;
        bypass_data = inflight_err_q ? '0 : sram_douta;

        bus.resp_valid = ~fifo_empty | inflight_q;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        if (!fifo_empty) begin
            bus.resp_rdata = fifo_data_q[rd_ptr_q];
            bus.resp_err   = fifo_err_q[rd_ptr_q];
        end else if (inflight_q) begin
            bus.resp_rdata = bypass_data;
            bus.resp_err   = bypass_err;
        end

        pop          = ~fifo_empty & bus.resp_ready;
        bypass_taken = fifo_empty & inflight_q & bus.resp_ready;
        push         = inflight_q & ~bypass_taken;
    end

    // In-flight tracker: one accepted access per cycle, carrying its error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            inflight_q     <= accept;
            inflight_err_q <= accept & ~in_range;
        end
    end

    // Queue storage and write pointer: capture an in-flight result that was
    // not handed straight to the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= bypass_data;
            fifo_err_q[wr_ptr_q]  <= bypass_err;
            wr_ptr_q              <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    // Read pointer: advance when the core takes the queue head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
        end else if (pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The ready rule guarantees the queue never overflows or underflows.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == FULL)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && fifo_empty));
    a_outstanding:  assert property (@(posedge clk) disable iff (!rst_n)
        (outstanding <= LIMIT));
endmodule

// File: tb/tb_sram_req_bridge.sv
// Self-checking bench for sram_req_bridge: behavioural SRAM, a queue-based
// reference model of outstanding responses, and per-scenario test tasks.
module tb_sram_req_bridge;
    localparam int          RESP_DEPTH = 2;
    localparam int          DEPTH      = 32;
    localparam logic [31:0] BASE       = 32'h0000_1000;
    localparam logic [31:0] WINDOW     = 32'd128;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] sram_addr;
    logic [31:0] sram_dina;
    logic        sram_ena;
    logic [3:0]  sram_wea;
    logic [31:0] sram_douta;
    logic        sram_clear;

    int checks = 0;
    int errors = 0;

    sram_req_bridge_if #(.LEN_ADDR(32), .LEN_DATA(32)) bus ();

    sram_req_bridge #(
        .LEN_ADDR(32), .LEN_DATA(32), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .sram_addr(sram_addr), .sram_dina(sram_dina), .sram_ena(sram_ena),
        .sram_wea(sram_wea), .sram_douta(sram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_line,
                                          input logic [31:0] new_line,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_line;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_line[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM: 1-cycle latency, byte writes, dout = merged line, 0 when idle
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= '0;
            sram_douta <= '0;
        end else if (sram_ena) begin
            sram_mem[sram_addr[6:2]] <= merge(sram_mem[sram_addr[6:2]], sram_dina, sram_wea);
            sram_douta               <= merge(sram_mem[sram_addr[6:2]], sram_dina, sram_wea);
        end else begin
            sram_douta <= '0;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    resp_t       exp_q [$];
    logic        e_ready, e_valid, e_err, e_inr, e_accept, e_ena;
    logic [31:0] e_rdata, e_addr;
    logic [3:0]  e_wea;

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic rr);
        bus.req_valid  = v;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_wstrb  = ws;
        bus.resp_ready = rr;
    endtask

    // Move to the falling edge and derive what the bridge should show now.
    task automatic settle();
        @(negedge clk);
        e_ready  = (exp_q.size() < RESP_DEPTH);
        e_valid  = (exp_q.size() != 0);
        e_rdata  = e_valid ? exp_q[0].data : 32'h0;
        e_err    = e_valid ? exp_q[0].err : 1'b0;
        e_addr   = bus.req_addr - BASE;
        e_inr    = (e_addr < WINDOW);
        e_accept = bus.req_valid && e_ready;
        e_ena    = e_accept && e_inr;
        e_wea    = e_ena ? bus.req_wstrb : 4'h0;
    endtask

    // Apply this cycle's handshakes to the model, then step past the clock edge.
    task automatic advance();
        resp_t r;
        int    idx;
        if (e_valid && bus.resp_ready) void'(exp_q.pop_front());
        if (e_accept) begin
            if (e_inr) begin
                idx          = int'(e_addr >> 2);
                ref_mem[idx] = merge(ref_mem[idx], bus.req_wdata, bus.req_wstrb);
                r.data       = ref_mem[idx];
                r.err        = 1'b0;
            end else begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rst_n = 1'b0;
        sram_clear = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err got %b want 0", bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
        checks++; if (sram_ena !== 1'b0) begin errors++; $display("[TB] FAIL reset_sram_ena got %b want 0", sram_ena); end
        checks++; if (sram_wea !== 4'h0) begin errors++; $display("[TB] FAIL reset_sram_wea got %h want 0", sram_wea); end
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sram_clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        drive(1'b1, BASE, $urandom, 4'h0, 1'b1);
        settle();
        checks++; if (sram_ena !== e_ena) begin errors++; $display("[TB] FAIL read_ena got %b want %b", sram_ena, e_ena); end
        checks++; if (sram_addr !== e_addr) begin errors++; $display("[TB] FAIL read_addr got %h want %h", sram_addr, e_addr); end
        checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL read_early_valid got %b want %b", bus.resp_valid, e_valid); end
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
        settle();
        checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL read_resp_valid got %b want %b", bus.resp_valid, e_valid); end
        checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL read_rdata got %h want %h", bus.resp_rdata, e_rdata); end
        checks++; if (bus.resp_err !== e_err) begin errors++; $display("[TB] FAIL read_err got %b want %b", bus.resp_err, e_err); end
        advance();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b1, BASE, 32'hA5A5_A5A5, 4'b0011, 1'b1);
            else if (i == 1) drive(1'b1, BASE + 32'd2, 32'h0, 4'h0, 1'b1);
            else             drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            checks++; if (sram_wea !== e_wea) begin errors++; $display("[TB] FAIL wr_wea cyc %0d got %h want %h", i, sram_wea, e_wea); end
            checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL wr_valid cyc %0d got %b want %b", i, bus.resp_valid, e_valid); end
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL wr_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) begin
            if (i < 8)       drive(1'b1, BASE + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 1'b1);
            else if (i < 16) drive(1'b1, BASE + 32'(4 * (i - 8)), $urandom, 4'h0, 1'b1);
            else             drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready cyc %0d got %b want 1", i, bus.req_ready); end
            checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL b2b_valid cyc %0d got %b want %b", i, bus.resp_valid, e_valid); end
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL b2b_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) begin
            if (i < 4) drive(1'b1, BASE + 32'(4 * (i + 3)), 32'h0, 4'h0, 1'b0);
            else       drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            checks++; if (bus.req_ready !== e_ready) begin errors++; $display("[TB] FAIL bp_ready cyc %0d got %b want %b", i, bus.req_ready, e_ready); end
            checks++; if (sram_ena !== e_ena) begin errors++; $display("[TB] FAIL bp_ena cyc %0d got %b want %b", i, sram_ena, e_ena); end
            checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL bp_valid cyc %0d got %b want %b", i, bus.resp_valid, e_valid); end
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL bp_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [5];
        addrs[0] = BASE + 32'h80;
        addrs[1] = BASE - 32'd4;
        addrs[2] = BASE + 32'hFFC;
        addrs[3] = BASE + 32'h7C;
        addrs[4] = BASE;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b1, addrs[i], $urandom, (i == 1) ? 4'hF : 4'h0, 1'b1);
            else       drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            checks++; if (sram_ena !== e_ena) begin errors++; $display("[TB] FAIL oor_ena cyc %0d got %b want %b", i, sram_ena, e_ena); end
            checks++; if (sram_wea !== e_wea) begin errors++; $display("[TB] FAIL oor_wea cyc %0d got %h want %h", i, sram_wea, e_wea); end
            if (e_valid) begin
                checks++; if (bus.resp_err !== e_err) begin errors++; $display("[TB] FAIL oor_err cyc %0d got %b want %b", i, bus.resp_err, e_err); end
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL oor_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 99) < 85) ? BASE + 32'($urandom_range(0, 127)) : $urandom;
            drive($urandom_range(0, 3) != 0, a, $urandom,
                  ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 7);
            settle();
            checks++; if (bus.req_ready !== e_ready) begin errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", i, bus.req_ready, e_ready); end
            checks++; if (sram_ena !== e_ena) begin errors++; $display("[TB] FAIL rnd_ena cyc %0d got %b want %b", i, sram_ena, e_ena); end
            checks++; if (sram_wea !== e_wea) begin errors++; $display("[TB] FAIL rnd_wea cyc %0d got %h want %h", i, sram_wea, e_wea); end
            checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", i, bus.resp_valid, e_valid); end
            if (e_ena) begin
                checks++; if (sram_addr !== e_addr) begin errors++; $display("[TB] FAIL rnd_addr cyc %0d got %h want %h", i, sram_addr, e_addr); end
                checks++; if (sram_dina !== bus.req_wdata) begin errors++; $display("[TB] FAIL rnd_dina cyc %0d got %h want %h", i, sram_dina, bus.req_wdata); end
            end
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL rnd_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
                checks++; if (bus.resp_err !== e_err) begin errors++; $display("[TB] FAIL rnd_err cyc %0d got %b want %b", i, bus.resp_err, e_err); end
            end
            advance();
        end
        // Drain whatever is still outstanding before the next scenario.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL drain_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, BASE + 32'd4, 32'h0, 4'h0, 1'b0);
        settle(); advance();
        drive(1'b1, BASE + 32'd8, 32'h0, 4'h0, 1'b0);
        settle(); advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        settle();
        checks++; if (bus.req_ready !== e_ready) begin errors++; $display("[TB] FAIL mid_pre_ready got %b want %b", bus.req_ready, e_ready); end
        checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL mid_pre_valid got %b want %b", bus.resp_valid, e_valid); end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready got %b want 1", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) drive(1'b1, BASE + 32'd4, 32'h0, 4'h0, 1'b1);
            else        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
            settle();
            checks++; if (bus.resp_valid !== e_valid) begin errors++; $display("[TB] FAIL mid_post_valid cyc %0d got %b want %b", i, bus.resp_valid, e_valid); end
            checks++; if (bus.req_ready !== e_ready) begin errors++; $display("[TB] FAIL mid_post_ready cyc %0d got %b want %b", i, bus.req_ready, e_ready); end
            if (e_valid) begin
                checks++; if (bus.resp_rdata !== e_rdata) begin errors++; $display("[TB] FAIL mid_post_rdata cyc %0d got %h want %h", i, bus.resp_rdata, e_rdata); end
            end
            advance();
        end
    endtask

    initial begin
        $display("[TB] starting sram_req_bridge bench");
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
